// File: rtl/wf_fetch_seq.sv
// wf_fetch_seq: read-side sequencer for the LSTM weight ROM.
// Walks a contiguous (wrapping) address window of a combinational ROM,
// registers each wide word and streams it out over valid/ready, then
// pulses done (and err for an out-of-range base address).
// Optional checksum of accepted words: define WF_CSUM_EN to build it;
// otherwise csum is tied to zero.
`timescale 1ns/1ps

module wf_fetch_seq #(
  parameter int D_WL      = 24,
  parameter int UNITS_NUM = 5,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 156
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W-1:0]         len,
  output logic                      busy,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [UNITS_NUM*D_WL-1:0] rom_data,
  output logic                      w_valid,
  input  logic                      w_ready,
  output logic [UNITS_NUM*D_WL-1:0] w_data,
  output logic                      w_last,
  output logic                      done,
  output logic                      err,
  output logic [D_WL-1:0]           csum
);

  localparam int W = UNITS_NUM * D_WL;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   rom_addr_q;
  logic [ADDR_W-1:0]   remaining_q;
  logic [W-1:0]        w_data_q;
  logic                w_valid_q;
  logic                w_last_q;
  logic                err_flag_q;

  logic start_acc;
  logic base_bad;
  logic len_zero;
  logic load;
  logic hs;

  // Widen by one bit so the range check still works if DEPTH == 2**ADDR_W.
  assign base_bad  = {1'b0, base_addr} >= (ADDR_W+1)'(DEPTH);
  assign len_zero  = (len == '0);
  assign start_acc = (state_q == S_IDLE) && start;
  assign hs        = w_valid_q && w_ready;
  // A new word may enter the output register when it is empty or being drained this cycle.
  assign load      = (state_q == S_RUN) && (remaining_q != '0) && (!w_valid_q || w_ready);

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_zero || base_bad) state_d = S_DONE;
          else                      state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (load && (remaining_q == ADDR_W'(1))) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (hs) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the current state.
  always_comb begin
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
    err  = (state_q == S_DONE) && err_flag_q;
  end

  // Address walker, word register and handshake state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q  <= '0;
      remaining_q <= '0;
      w_data_q    <= '0;
      w_valid_q   <= 1'b0;
      w_last_q    <= 1'b0;
      err_flag_q  <= 1'b0;
    end else begin
      if (start_acc) begin
        err_flag_q <= base_bad;
        if (!base_bad && !len_zero) begin
          rom_addr_q  <= base_addr;
          remaining_q <= len;
        end
      end
      if (load) begin
        w_data_q    <= rom_data;
        w_valid_q   <= 1'b1;
        w_last_q    <= (remaining_q == ADDR_W'(1));
        remaining_q <= remaining_q - ADDR_W'(1);
        rom_addr_q  <= (rom_addr_q == LAST_ADDR) ? '0 : rom_addr_q + ADDR_W'(1);
      end else if ((state_q == S_DRAIN) && hs) begin
        w_valid_q <= 1'b0;
        w_last_q  <= 1'b0;
      end
    end
  end

  assign rom_addr = rom_addr_q;
  assign w_data   = w_data_q;
  assign w_valid  = w_valid_q;
  assign w_last   = w_last_q;

`ifdef WF_CSUM_EN
  logic [D_WL-1:0] lane_xor;
  logic [D_WL-1:0] csum_q;

  // XOR-fold all lanes of the word currently on the output.
  always_comb begin
    lane_xor = '0;
    for (int i = 0; i < UNITS_NUM; i++) begin
      lane_xor = lane_xor ^ w_data_q[i*D_WL +: D_WL];
    end
  end

  // Checksum accumulates every accepted word; restarts with each accepted command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)            csum_q <= '0;
    else if (start_acc) csum_q <= '0;
    else if (hs)        csum_q <= csum_q ^ lane_xor;
  end

  assign csum = csum_q;
`else
  assign csum = '0;
`endif

endmodule
